// File: rtl/riscv_pkg.sv
// Shared core definitions: machine word width and the skid-buffer occupancy encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Occupancy of a two-entry skid stage: nothing held, main only, main plus skid.
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_t;

endpackage : riscv_pkg

// File: rtl/pipe_skid.sv
// Two-entry valid/ready skid buffer. The main register drives the output.
// The skid register catches the one beat that arrives while the consumer stalls.
// Upstream ready depends only on registered state and flush, so ready paths
// between pipeline stages are cut.
module pipe_skid
  import riscv_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         valid_q, valid_d;
  logic         in_fire_s;
  logic         out_fire_s;

  // Handshake qualifiers; in_ready is blocked while both entries are held or a flush is in progress.
  always_comb begin
    in_ready   = (state_q != SK_FULL) && !flush;
    in_fire_s  = in_valid && in_ready;
    out_fire_s = valid_q && out_ready;
  end

  // Next-state and data-movement decisions; flush overrides every occupancy transition.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Data registers are left alone; they are invisible once out_valid drops.
      state_d = SK_EMPTY;
    end else begin
      case (state_q)
        SK_EMPTY: begin
          if (in_fire_s) begin
            main_d  = in_data;
            state_d = SK_ONE;
          end else begin
            state_d = SK_EMPTY;
          end
        end
        SK_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d  = in_data;
            state_d = SK_ONE;
          end else if (in_fire_s) begin
            skid_d  = in_data;
            state_d = SK_FULL;
          end else if (out_fire_s) begin
            state_d = SK_EMPTY;
          end else begin
            state_d = SK_ONE;
          end
        end
        SK_FULL: begin
          if (out_fire_s) begin
            main_d  = skid_q;
            state_d = SK_ONE;
          end else begin
            state_d = SK_FULL;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage.
          state_d = SK_EMPTY;
        end
      endcase
    end
    valid_d = (state_d != SK_EMPTY);
  end

  // Occupancy and output-valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SK_EMPTY;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  // Main data register; it feeds out_data directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
    end else begin
      main_q <= main_d;
    end
  end

  // Skid data register; it holds the beat that is accepted while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_q <= '0;
    end else begin
      skid_q <= skid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = main_q;

endmodule : pipe_skid

// File: tb/tb_pipe_skid.sv
// Self-checking bench for pipe_skid: directed scenarios plus random back-pressure,
// with a FIFO scoreboard fed on every accepted input beat and drained on every output beat.
module tb_pipe_skid;
  import riscv_pkg::*;

  localparam int unsigned W = XLEN;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int checks_q;
  int errors_q;
  int delivered_q;

  logic [W-1:0] sb_q[$];
  logic         hold_prev;
  logic [W-1:0] data_prev;

  pipe_skid #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks_q++;
    if (obs !== exp_v) begin
      errors_q++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: inputs and outputs are stable at the falling edge, and each
  // handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check_eq("hold_valid", {63'd0, out_valid}, 64'd1);
        check_eq("hold_data", {32'd0, out_data}, {32'd0, data_prev});
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
          check_eq("sb_data", {32'd0, out_data}, {32'd0, sb_q.pop_front()});
          delivered_q++;
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && in_ready) begin
        sb_q.push_back(in_data);
      end
      hold_prev <= out_valid && !out_ready && !flush;
      data_prev <= out_data;
    end
  end

  // Global time limit so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    int cycles;
    logic fire_v;
    logic [W-1:0] seq;

    checks_q    = 0;
    errors_q    = 0;
    delivered_q = 0;
    hold_prev   = 1'b0;
    data_prev   = '0;
    reset       = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;

    #12 reset = 1'b0;
    #1;
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_data", {32'd0, out_data}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Streaming with the consumer always ready.
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    check_eq("str_v0", {63'd0, out_valid}, 64'd1);
    check_eq("str_d0", {32'd0, out_data}, 64'h11);
    check_eq("str_r0", {63'd0, in_ready}, 64'd1);
    in_data = 32'h22;
    step();
    check_eq("str_d1", {32'd0, out_data}, 64'h22);
    check_eq("str_r1", {63'd0, in_ready}, 64'd1);
    in_data = 32'h33;
    step();
    check_eq("str_d2", {32'd0, out_data}, 64'h33);
    check_eq("str_r2", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b0;
    step();
    check_eq("str_drain", {63'd0, out_valid}, 64'd0);

    // Stall fill: two beats while the consumer is stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    check_eq("stl_state1", {62'd0, dut.state_q}, {62'd0, SK_ONE});
    check_eq("stl_d0", {32'd0, out_data}, 64'hA);
    in_data = 32'hB;
    step();
    check_eq("stl_full", {62'd0, dut.state_q}, {62'd0, SK_FULL});
    check_eq("stl_rdy0", {63'd0, in_ready}, 64'd0);
    check_eq("stl_hold", {32'd0, out_data}, 64'hA);
    in_valid = 1'b0;
    step();
    check_eq("stl_hold2", {32'd0, out_data}, 64'hA);
    out_ready = 1'b1;
    step();
    check_eq("stl_dB", {32'd0, out_data}, 64'hB);
    check_eq("stl_rdy1", {63'd0, in_ready}, 64'd1);
    step();
    check_eq("stl_empty", {63'd0, out_valid}, 64'd0);

    // Simultaneous input and output while one entry is held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    step();
    in_data   = 32'h6;
    out_ready = 1'b1;
    step();
    check_eq("sim_d", {32'd0, out_data}, 64'h6);
    check_eq("sim_state", {62'd0, dut.state_q}, {62'd0, SK_ONE});
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;

    // Flush while full with a beat offered.
    in_valid = 1'b1;
    in_data  = 32'h71;
    step();
    in_data = 32'h72;
    step();
    flush   = 1'b1;
    in_data = 32'h73;
    #1;
    check_eq("fl_rdy", {63'd0, in_ready}, 64'd0);
    step();
    flush = 1'b0;
    check_eq("fl_valid", {63'd0, out_valid}, 64'd0);
    check_eq("fl_state", {62'd0, dut.state_q}, {62'd0, SK_EMPTY});
    in_valid = 1'b0;
    step();
    check_eq("fl_nocap", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset with the stage full.
    in_valid = 1'b1;
    in_data  = 32'h81;
    step();
    in_data = 32'h82;
    step();
    in_valid = 1'b0;
    check_eq("rs_full", {62'd0, dut.state_q}, {62'd0, SK_FULL});
    #2 reset = 1'b1;
    #1;
    check_eq("rs_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rs_data", {32'd0, out_data}, 64'd0);
    step();
    #2 reset = 1'b0;
    #1;
    check_eq("rs_rdy", {63'd0, in_ready}, 64'd1);
    check_eq("rs_state", {62'd0, dut.state_q}, {62'd0, SK_EMPTY});

    // Random back-pressure: 1000 beats of increasing data.
    delivered_q = 0;
    step();
    sent   = 0;
    cycles = 0;
    seq    = 32'h1000;
    while (sent < 1000 && cycles < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = seq;
      #1;
      fire_v = in_valid && in_ready;
      step();
      if (fire_v) begin
        seq++;
        sent++;
      end
      cycles++;
    end
    check_eq("rnd_sent", sent, 64'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
    end
    check_eq("rnd_delivered", delivered_q, 64'd1000);
    check_eq("rnd_sb_empty", sb_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks_q, errors_q);
    $finish;
  end

endmodule : tb_pipe_skid
